// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes, the decode-error read pattern and the
// address-window compare used by the demux decoders.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam logic [31:0] DECERR_RDATA = 32'hDEAD_BEEF;

    // Bases are window-aligned, so only the bits above the window are compared.
    function automatic logic addr_decode(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int          win_bits);
        logic [63:0] win_mask;
        win_mask = (64'd1 << win_bits) - 64'd1;
        return (addr & ~win_mask) == base;
    endfunction

endpackage

// File: rtl/axi_lite_decoder.sv
// Combinational address -> {hit, slave index} lookup against the per-slave
// base table; lowest matching index wins.
module axi_lite_decoder
    import axi_lite_pkg::*;
#(
    parameter int NUM_SLV  = 4,
    parameter int ADDR_W   = 32,
    parameter int WIN_BITS = 12,
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] BASE_ADDR = '0,
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [SEL_W-1:0]  sel
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (addr_decode(64'(addr), 64'(BASE_ADDR[i]), WIN_BITS)) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_demux_n.sv
// 1-master -> NUM_SLV-slave AXI-Lite demux: independent read and write FSMs,
// one transaction each in flight, window rebasing, DECERR / SLVERR-on-timeout.
module axi_lite_demux_n
    import axi_lite_pkg::*;
#(
    parameter int NUM_SLV  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WIN_BITS = 12,
    // Every slave needs its own window-aligned base when instantiated.
    parameter logic [NUM_SLV-1:0][ADDR_W-1:0] BASE_ADDR = '0,
    parameter int TIMEOUT  = 1024,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                           aclk,
    input  logic                           areset,

    input  logic [ADDR_W-1:0]              s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_W-1:0]              s_wdata,
    input  logic [STRB_W-1:0]              s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_W-1:0]              s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_W-1:0]              s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,

    output logic [NUM_SLV-1:0][ADDR_W-1:0] m_awaddr,
    output logic [NUM_SLV-1:0]             m_awvalid,
    input  logic [NUM_SLV-1:0]             m_awready,
    output logic [NUM_SLV-1:0][DATA_W-1:0] m_wdata,
    output logic [NUM_SLV-1:0][STRB_W-1:0] m_wstrb,
    output logic [NUM_SLV-1:0]             m_wvalid,
    input  logic [NUM_SLV-1:0]             m_wready,
    input  logic [NUM_SLV-1:0][1:0]        m_bresp,
    input  logic [NUM_SLV-1:0]             m_bvalid,
    output logic [NUM_SLV-1:0]             m_bready,
    output logic [NUM_SLV-1:0][ADDR_W-1:0] m_araddr,
    output logic [NUM_SLV-1:0]             m_arvalid,
    input  logic [NUM_SLV-1:0]             m_arready,
    input  logic [NUM_SLV-1:0][DATA_W-1:0] m_rdata,
    input  logic [NUM_SLV-1:0][1:0]        m_rresp,
    input  logic [NUM_SLV-1:0]             m_rvalid,
    output logic [NUM_SLV-1:0]             m_rready
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'((64'd1 << WIN_BITS) - 64'd1);
    localparam logic [DATA_W-1:0] DEC_DATA = DATA_W'(DECERR_RDATA);

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA} rd_state_t;

    logic             aw_hit, ar_hit;
    logic [SEL_W-1:0] aw_sel_d, ar_sel_d;

    axi_lite_decoder #(
        .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .WIN_BITS(WIN_BITS), .BASE_ADDR(BASE_ADDR)
    ) u_aw_dec (
        .addr(s_awaddr), .hit(aw_hit), .sel(aw_sel_d)
    );

    axi_lite_decoder #(
        .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .WIN_BITS(WIN_BITS), .BASE_ADDR(BASE_ADDR)
    ) u_ar_dec (
        .addr(s_araddr), .hit(ar_hit), .sel(ar_sel_d)
    );

    // ---------------- write path ----------------
    wr_state_t        wstate;
    logic [SEL_W-1:0] wsel;
    logic [ADDR_W-1:0] awaddr_q;
    logic             aw_pend, w_pend;
    logic             w_err;        // transaction served by the internal error slave
    resp_t            w_eresp;
    logic [TMR_W-1:0] w_tmr;
    logic             aw_hs, w_hs, b_hs, w_wait, w_tmo;

    always_comb begin
        aw_hs  = (wstate == W_FWD) && aw_pend && s_awvalid && (w_err || m_awready[wsel]);
        w_hs   = (wstate == W_FWD) && w_pend && s_wvalid && (w_err || m_wready[wsel]);
        b_hs   = s_bvalid && s_bready;
        w_wait = 1'b0;
        if (!w_err) begin
            if (wstate == W_FWD)
                w_wait = (aw_pend && !aw_hs) || (w_pend && s_wvalid && !w_hs);
            else if (wstate == W_RESP)
                w_wait = !m_bvalid[wsel];
        end
        w_tmo = (TIMEOUT != 0) && w_wait && (w_tmr == TMR_LAST);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate   <= W_IDLE;
            wsel     <= '0;
            awaddr_q <= '0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            w_err    <= 1'b0;
            w_eresp  <= OKAY;
            w_tmr    <= '0;
        end else begin
            case (wstate)
                W_IDLE: if (s_awvalid) begin
                    wstate   <= W_FWD;
                    wsel     <= aw_sel_d;
                    awaddr_q <= s_awaddr;
                    aw_pend  <= 1'b1;
                    w_pend   <= 1'b1;
                    w_err    <= !aw_hit;
                    w_eresp  <= aw_hit ? OKAY : DECERR;
                    w_tmr    <= '0;
                end
                W_FWD: begin
                    if (aw_hs) aw_pend <= 1'b0;
                    if (w_hs)  w_pend  <= 1'b0;
                    if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) begin
                        wstate <= W_RESP;
                        w_tmr  <= '0;
                    end else if (w_tmo) begin
                        // Internal slave swallows whatever is still pending.
                        w_err   <= 1'b1;
                        w_eresp <= SLVERR;
                    end else if (w_wait) begin
                        w_tmr <= w_tmr + 1'b1;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        wstate <= W_IDLE;
                        w_err  <= 1'b0;
                    end else if (w_tmo) begin
                        w_err   <= 1'b1;
                        w_eresp <= SLVERR;
                    end else if (w_wait) begin
                        w_tmr <= w_tmr + 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign s_awready = aw_hs;
    assign s_wready  = w_hs;
    assign s_bvalid  = (wstate == W_RESP) && (w_err || m_bvalid[wsel]);
    assign s_bresp   = (wstate != W_RESP) ? OKAY : (w_err ? w_eresp : m_bresp[wsel]);

    // ---------------- read path ----------------
    rd_state_t        rstate;
    logic [SEL_W-1:0] rsel;
    logic [ADDR_W-1:0] araddr_q;
    logic             r_err;
    resp_t            r_eresp;
    logic [TMR_W-1:0] r_tmr;
    logic             ar_hs, r_hs, r_wait, r_tmo;

    always_comb begin
        ar_hs  = (rstate == R_FWD) && s_arvalid && (r_err || m_arready[rsel]);
        r_hs   = s_rvalid && s_rready;
        r_wait = 1'b0;
        if (!r_err) begin
            if (rstate == R_FWD)
                r_wait = !m_arready[rsel];
            else if (rstate == R_DATA)
                r_wait = !m_rvalid[rsel];
        end
        r_tmo = (TIMEOUT != 0) && r_wait && (r_tmr == TMR_LAST);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate   <= R_IDLE;
            rsel     <= '0;
            araddr_q <= '0;
            r_err    <= 1'b0;
            r_eresp  <= OKAY;
            r_tmr    <= '0;
        end else begin
            case (rstate)
                R_IDLE: if (s_arvalid) begin
                    rstate   <= R_FWD;
                    rsel     <= ar_sel_d;
                    araddr_q <= s_araddr;
                    r_err    <= !ar_hit;
                    r_eresp  <= ar_hit ? OKAY : DECERR;
                    r_tmr    <= '0;
                end
                R_FWD: begin
                    if (ar_hs) begin
                        rstate <= R_DATA;
                        r_tmr  <= '0;
                    end else if (r_tmo) begin
                        r_err   <= 1'b1;
                        r_eresp <= SLVERR;
                    end else if (r_wait) begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        rstate <= R_IDLE;
                        r_err  <= 1'b0;
                    end else if (r_tmo) begin
                        r_err   <= 1'b1;
                        r_eresp <= SLVERR;
                    end else if (r_wait) begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign s_arready = ar_hs;
    assign s_rvalid  = (rstate == R_DATA) && (r_err || m_rvalid[rsel]);
    assign s_rresp   = (rstate != R_DATA) ? OKAY : (r_err ? r_eresp : m_rresp[rsel]);
    assign s_rdata   = (rstate != R_DATA) ? '0 :
                       !r_err             ? m_rdata[rsel] :
                       (r_eresp == DECERR) ? DEC_DATA : '0;

    // ---------------- per-slave fan-out ----------------
    logic w_live, r_live;
    assign w_live = !w_err;
    assign r_live = !r_err;

    for (genvar i = 0; i < NUM_SLV; i++) begin : g_slv
        logic w_is, r_is;
        assign w_is = (wsel == SEL_W'(i));
        assign r_is = (rsel == SEL_W'(i));

        assign m_awaddr[i]  = awaddr_q & WIN_MASK;
        assign m_awvalid[i] = (wstate == W_FWD) && w_live && aw_pend && w_is;
        assign m_wdata[i]   = s_wdata;
        assign m_wstrb[i]   = s_wstrb;
        assign m_wvalid[i]  = (wstate == W_FWD) && w_live && w_pend && s_wvalid && w_is;
        assign m_bready[i]  = (wstate == W_RESP) && w_live && s_bready && w_is;

        assign m_araddr[i]  = araddr_q & WIN_MASK;
        assign m_arvalid[i] = (rstate == R_FWD) && r_live && r_is;
        assign m_rready[i]  = (rstate == R_DATA) && r_live && s_rready && r_is;
    end

endmodule
